// File: rtl/dmem_sized_ws.sv
// Wait-stated MIPS data memory with byte/half/word access, load extension and address-error check.
// Optional macro DMEM_CLEAR_EN adds a post-reset CLEAR pass that zeroes every word.
module dmem_sized_ws #(
   parameter int unsigned DEPTH       = 1024,
   parameter int unsigned WAIT_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] Address,
   input  logic [31:0] WriteData,
   input  logic        MemWrite,
   input  logic        MemRead,
   input  logic [1:0]  Size,
   input  logic        Unsigned,
   output logic        Ready,
   output logic [31:0] ReadData,
   output logic        ReadValid,
   output logic        AddrErr
);

   localparam int unsigned AW = $clog2(DEPTH);

   typedef enum logic [1:0] {StIdle, StWait, StResp, StClear} state_e;

`ifdef DMEM_CLEAR_EN
   localparam state_e StReset = StClear;
`else
   localparam state_e StReset = StIdle;
`endif

   state_e        state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic [AW+1:0] addr_q, addr_d;
   logic [31:0]   wdata_q, wdata_d;
   logic [1:0]    size_q, size_d;
   logic          uns_q, uns_d;
   logic          write_q, write_d;
   logic          err_q, err_d;
   logic [31:0]   rdata_q, rdata_d;

`ifdef DMEM_CLEAR_EN
   logic [AW-1:0] clr_idx_q, clr_idx_d;
`endif

   logic [31:0]   mem [DEPTH];
   logic          mem_we;
   logic [AW-1:0] mem_idx;
   logic [31:0]   mem_wdata;

   logic [AW+1:0] cur_addr;
   logic [31:0]   cur_wdata;
   logic [1:0]    cur_size;
   logic          cur_uns;
   logic          cur_write;
   logic          req_err;
   logic          commit;
   logic [31:0]   old_word;
   logic [31:0]   merged;
   logic [7:0]    lane_b;
   logic [15:0]   lane_h;

   assign Ready     = (state_q == StIdle);
   assign ReadData  = rdata_q;
   assign ReadValid = (state_q == StResp) && !err_q && !write_q;
   assign AddrErr   = (state_q == StResp) && err_q;

   always_comb begin
      req_err = 1'b0;
      if (MemRead && MemWrite) req_err = 1'b1;
      if (Size == 2'b11) req_err = 1'b1;
      if ((Size == 2'b01) && Address[0]) req_err = 1'b1;
      if ((Size == 2'b10) && (Address[1:0] != 2'b00)) req_err = 1'b1;
      if ({2'b00, Address[31:2]} >= DEPTH) req_err = 1'b1;
   end

   // With zero wait states the commit happens on the accept edge, so use the live inputs.
   always_comb begin
      if (state_q == StIdle) begin
         cur_addr  = Address[AW+1:0];
         cur_wdata = WriteData;
         cur_size  = Size;
         cur_uns   = Unsigned;
         cur_write = MemWrite;
      end else begin
         cur_addr  = addr_q;
         cur_wdata = wdata_q;
         cur_size  = size_q;
         cur_uns   = uns_q;
         cur_write = write_q;
      end
   end

   always_comb begin
      old_word = mem[cur_addr[AW+1:2]];
      lane_b   = old_word[{cur_addr[1:0], 3'b000} +: 8];
      lane_h   = old_word[{cur_addr[1], 4'b0000} +: 16];
      merged   = old_word;
      case (cur_size)
         2'b00:   merged[{cur_addr[1:0], 3'b000} +: 8] = cur_wdata[7:0];
         2'b01:   merged[{cur_addr[1], 4'b0000} +: 16] = cur_wdata[15:0];
         default: merged = cur_wdata;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      size_d    = size_q;
      uns_d     = uns_q;
      write_d   = write_q;
      err_d     = err_q;
      rdata_d   = rdata_q;
      commit    = 1'b0;
      mem_we    = 1'b0;
      mem_idx   = cur_addr[AW+1:2];
      mem_wdata = merged;
`ifdef DMEM_CLEAR_EN
      clr_idx_d = clr_idx_q;
`endif

      case (state_q)
         StIdle: begin
            if (MemRead || MemWrite) begin
               addr_d  = Address[AW+1:0];
               wdata_d = WriteData;
               size_d  = Size;
               uns_d   = Unsigned;
               write_d = MemWrite;
               err_d   = req_err;
               if (req_err) begin
                  state_d = StResp;
               end else if (WAIT_CYCLES == 0) begin
                  state_d = StResp;
                  commit  = 1'b1;
               end else begin
                  state_d = StWait;
                  cnt_d   = 4'(WAIT_CYCLES);
               end
            end
         end
         StWait: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               state_d = StResp;
               commit  = 1'b1;
            end
         end
         StResp: state_d = StIdle;
`ifdef DMEM_CLEAR_EN
         StClear: begin
            mem_we    = 1'b1;
            mem_idx   = clr_idx_q;
            mem_wdata = 32'h0;
            clr_idx_d = clr_idx_q + AW'(1);
            if (clr_idx_q == AW'(DEPTH - 1)) state_d = StIdle;
         end
`endif
         default: state_d = StIdle;
      endcase

      if (commit) begin
         if (cur_write) begin
            mem_we = 1'b1;
         end else begin
            case (cur_size)
               2'b00:   rdata_d = {{24{lane_b[7] & ~cur_uns}}, lane_b};
               2'b01:   rdata_d = {{16{lane_h[15] & ~cur_uns}}, lane_h};
               default: rdata_d = old_word;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StReset;
         cnt_q   <= 4'd0;
         addr_q  <= '0;
         wdata_q <= 32'h0;
         size_q  <= 2'b00;
         uns_q   <= 1'b0;
         write_q <= 1'b0;
         err_q   <= 1'b0;
         rdata_q <= 32'h0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         size_q  <= size_d;
         uns_q   <= uns_d;
         write_q <= write_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
      end
   end

`ifdef DMEM_CLEAR_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clr_idx_q <= '0;
      end else begin
         clr_idx_q <= clr_idx_d;
      end
   end
`endif

   // Array is not reset; a store in flight at reset never reaches its commit edge.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[mem_idx] <= mem_wdata;
      end
   end

endmodule

// File: tb/tb_dmem_sized_ws.sv
// Directed bench for dmem_sized_ws: a WAIT_CYCLES=1/DEPTH=1024 instance and a
// WAIT_CYCLES=0/DEPTH=16 instance for back-to-back (and clear, when DMEM_CLEAR_EN is set).
module tb_dmem_sized_ws;

   logic        clk;
   logic        rst_n, rst0_n;
   logic [31:0] Address, WriteData;
   logic [1:0]  Size;
   logic        Unsigned;
   logic        mr1, mw1, mr0, mw0;
   logic        ready1, rv1, ae1, ready0, rv0, ae0;
   logic [31:0] rd1, rd0;
   bit          sel_q;
   logic        s_ready, s_rv, s_ae;
   logic [31:0] s_rd;
   int          errors = 0;
   int          checks = 0;

`ifdef DMEM_CLEAR_EN
   localparam logic RST_READY = 1'b0;
   localparam logic [31:0] OLD20 = 32'h0;
`else
   localparam logic RST_READY = 1'b1;
   localparam logic [31:0] OLD20 = 32'h1111_1111;
`endif

   dmem_sized_ws #(.DEPTH(1024), .WAIT_CYCLES(1)) dut (
      .clk(clk), .rst_n(rst_n), .Address(Address), .WriteData(WriteData),
      .MemWrite(mw1), .MemRead(mr1), .Size(Size), .Unsigned(Unsigned),
      .Ready(ready1), .ReadData(rd1), .ReadValid(rv1), .AddrErr(ae1)
   );

   dmem_sized_ws #(.DEPTH(16), .WAIT_CYCLES(0)) dut0 (
      .clk(clk), .rst_n(rst0_n), .Address(Address), .WriteData(WriteData),
      .MemWrite(mw0), .MemRead(mr0), .Size(Size), .Unsigned(Unsigned),
      .Ready(ready0), .ReadData(rd0), .ReadValid(rv0), .AddrErr(ae0)
   );

   assign s_ready = sel_q ? ready0 : ready1;
   assign s_rv    = sel_q ? rv0 : rv1;
   assign s_ae    = sel_q ? ae0 : ae1;
   assign s_rd    = sel_q ? rd0 : rd1;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Drives one request for a single cycle, then observes until Ready returns (bounded).
   task automatic access(input bit sel, input bit rd_en, input bit wr_en,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [1:0] sz, input bit uns,
                         output int busy, output int rv_cyc, output int ae_cyc,
                         output logic [31:0] rd);
      busy = 0; rv_cyc = 0; ae_cyc = 0; rd = 32'h0;
      sel_q = sel;
      @(negedge clk);
      Address = addr; WriteData = wd; Size = sz; Unsigned = uns;
      if (sel) begin mr0 = rd_en; mw0 = wr_en; end
      else begin mr1 = rd_en; mw1 = wr_en; end
      @(negedge clk);
      mr0 = 0; mw0 = 0; mr1 = 0; mw1 = 0;
      for (int n = 1; n <= 20; n++) begin
         if (!s_ready) busy++;
         if (s_rv) begin rv_cyc = n; rd = s_rd; end
         if (s_ae) ae_cyc = n;
         if (s_ready) break;
         @(negedge clk);
      end
   endtask

   task automatic wait_ready(input bit sel);
      bit ok;
      ok = 0;
      sel_q = sel;
      for (int n = 0; n < 3000; n++) begin
         if (s_ready) begin ok = 1; break; end
         @(negedge clk);
      end
      checks++;
      if (ok !== 1'b1) begin errors++; $display("FAIL wait_ready%0d: Ready never rose", sel); end
   endtask

   task automatic test_reset;
      sel_q = 0;
      repeat (2) @(negedge clk);
      checks++; if (ready1 !== RST_READY) begin
         errors++; $display("FAIL rst_ready: got %b want %b", ready1, RST_READY); end
      checks++; if (rv1 !== 1'b0) begin errors++; $display("FAIL rst_rv: got %b want 0", rv1); end
      checks++; if (ae1 !== 1'b0) begin errors++; $display("FAIL rst_ae: got %b want 0", ae1); end
      checks++; if (rd1 !== 32'h0) begin errors++; $display("FAIL rst_rd: got %h want 0", rd1); end
      rst_n = 1; rst0_n = 1;
      wait_ready(0);
      wait_ready(1);
   endtask

   task automatic test_word;
      int b, v, e; logic [31:0] r;
      access(0, 0, 1, 32'h10, 32'hDEAD_BEEF, 2'b10, 0, b, v, e, r);
      checks++; if (b !== 2) begin errors++; $display("FAIL sw_busy: got %0d want 2", b); end
      checks++; if (v !== 0 || e !== 0) begin
         errors++; $display("FAIL sw_pulses: got rv=%0d ae=%0d want 0 0", v, e); end
      access(0, 1, 0, 32'h10, 32'h0, 2'b10, 0, b, v, e, r);
      checks++; if (b !== 2) begin errors++; $display("FAIL lw_busy: got %0d want 2", b); end
      checks++; if (v !== 2) begin errors++; $display("FAIL lw_latency: got %0d want 2", v); end
      checks++; if (r !== 32'hDEAD_BEEF) begin
         errors++; $display("FAIL lw_data: got %h want deadbeef", r); end
   endtask

   task automatic test_byte_half;
      int b, v, e; logic [31:0] r;
      logic [31:0] addrs [8] = '{32'h10, 32'h12, 32'h12, 32'h12, 32'h10, 32'h10, 32'h13, 32'h24};
      logic [1:0]  sizes [8] = '{2'b10, 2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 2'b00, 2'b10};
      bit          unss  [8] = '{0, 0, 1, 0, 0, 1, 0, 0};
      logic [31:0] exps  [8] = '{32'h7FAD_BEEF, 32'hFFFF_FFAD, 32'h0000_00AD, 32'h0000_7FAD,
                                 32'hFFFF_BEEF, 32'h0000_BEEF, 32'h0000_007F, 32'h5678_0000};
      access(0, 0, 1, 32'h13, 32'hABCD_127F, 2'b00, 0, b, v, e, r);
      access(0, 0, 1, 32'h24, 32'h0, 2'b10, 0, b, v, e, r);
      access(0, 0, 1, 32'h26, 32'h9999_5678, 2'b01, 0, b, v, e, r);
      for (int i = 0; i < 8; i++) begin
         access(0, 1, 0, addrs[i], 32'h0, sizes[i], unss[i], b, v, e, r);
         checks++; if (v !== 2 || r !== exps[i]) begin
            errors++;
            $display("FAIL load%0d @%h: got %h (rv cyc %0d) want %h", i, addrs[i], r, v, exps[i]);
         end
      end
   endtask

   task automatic test_errors;
      int b, v, e; logic [31:0] r;
      logic [31:0] addrs [4] = '{32'h11, 32'h12, 32'h10, 32'h11};
      logic [1:0]  sizes [4] = '{2'b01, 2'b10, 2'b11, 2'b01};
      bit          wr    [4] = '{0, 0, 0, 1};
      for (int i = 0; i < 4; i++) begin
         access(0, !wr[i], wr[i], addrs[i], 32'h1234, sizes[i], 0, b, v, e, r);
         checks++; if (e !== 1 || v !== 0 || b !== 1) begin
            errors++; $display("FAIL err%0d: got ae=%0d rv=%0d busy=%0d want 1 0 1", i, e, v, b);
         end
      end
      checks++; if (rd1 !== 32'h5678_0000) begin
         errors++; $display("FAIL err_rd_hold: got %h want 56780000", rd1); end
      access(0, 1, 0, 32'h10, 32'h0, 2'b10, 0, b, v, e, r);
      checks++; if (r !== 32'h7FAD_BEEF) begin
         errors++; $display("FAIL err_mem: got %h want 7fadbeef", r); end
   endtask

   task automatic test_range;
      int b, v, e; logic [31:0] r;
      access(0, 0, 1, 32'h0, 32'hCAFE_F00D, 2'b10, 0, b, v, e, r);
      access(0, 0, 1, 32'hFFC, 32'h0BAD_CAFE, 2'b10, 0, b, v, e, r);
      checks++; if (e !== 0 || b !== 2) begin
         errors++; $display("FAIL top_word: got ae=%0d busy=%0d want 0 2", e, b); end
      access(0, 0, 1, 32'h1000, 32'h1234_5678, 2'b10, 0, b, v, e, r);
      checks++; if (e !== 1) begin errors++; $display("FAIL oor_ae: got %0d want 1", e); end
      access(0, 1, 1, 32'h0, 32'h0, 2'b10, 0, b, v, e, r);
      checks++; if (e !== 1 || v !== 0) begin
         errors++; $display("FAIL both_ae: got ae=%0d rv=%0d want 1 0", e, v); end
      access(0, 1, 0, 32'h0, 32'h0, 2'b10, 0, b, v, e, r);
      checks++; if (r !== 32'hCAFE_F00D) begin
         errors++; $display("FAIL oor_mem: got %h want cafef00d", r); end
      access(0, 1, 0, 32'hFFC, 32'h0, 2'b10, 0, b, v, e, r);
      checks++; if (r !== 32'h0BAD_CAFE) begin
         errors++; $display("FAIL top_read: got %h want 0badcafe", r); end
   endtask

   task automatic test_reset_mid;
      int b, v, e; logic [31:0] r;
      access(0, 0, 1, 32'h20, 32'h1111_1111, 2'b10, 0, b, v, e, r);
      sel_q = 0;
      @(negedge clk);
      Address = 32'h20; WriteData = 32'h2222_2222; Size = 2'b10; mw1 = 1;
      @(negedge clk);
      mw1 = 0;
      checks++; if (ready1 !== 1'b0) begin
         errors++; $display("FAIL mid_wait: got Ready=%b want 0", ready1); end
      rst_n = 0;
      #1;
      checks++; if (ready1 !== RST_READY || rv1 !== 1'b0 || ae1 !== 1'b0 || rd1 !== 32'h0) begin
         errors++;
         $display("FAIL mid_rst: got rdy=%b rv=%b ae=%b rd=%h want %b 0 0 0",
                  ready1, rv1, ae1, rd1, RST_READY);
      end
      @(negedge clk);
      rst_n = 1;
      wait_ready(0);
      access(0, 1, 0, 32'h20, 32'h0, 2'b10, 0, b, v, e, r);
      checks++; if (r !== OLD20) begin
         errors++; $display("FAIL mid_mem: got %h want %h", r, OLD20); end
   endtask

   task automatic test_back_to_back;
      int b, v, e; logic [31:0] r;
      access(1, 0, 1, 32'h0, 32'hA5A5_A5A5, 2'b10, 0, b, v, e, r);
      checks++; if (b !== 1) begin errors++; $display("FAIL w0_busy: got %0d want 1", b); end
      access(1, 0, 1, 32'h4, 32'h5A5A_0001, 2'b10, 0, b, v, e, r);
      sel_q = 1;
      @(negedge clk);
      Address = 32'h0; Size = 2'b10; Unsigned = 0; mr0 = 1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         checks++; if (rv0 !== ((k % 2) == 0)) begin
            errors++; $display("FAIL b2b_rv%0d: got %b want %b", k, rv0, (k % 2) == 0); end
         if ((k % 2) == 0) begin
            checks++;
            if (rd0 !== ((k == 2) ? 32'h5A5A_0001 : 32'hA5A5_A5A5)) begin
               errors++; $display("FAIL b2b_rd%0d: got %h", k, rd0); end
         end else if (k == 5) begin
            mr0 = 0;
         end else begin
            Address = (k == 1) ? 32'h4 : 32'h0;
         end
      end
      @(negedge clk);
   endtask

`ifdef DMEM_CLEAR_EN
   task automatic test_clear;
      int b, v, e, cnt; logic [31:0] r;
      access(1, 0, 1, 32'h3C, 32'hFFFF_FFFF, 2'b10, 0, b, v, e, r);
      @(negedge clk);
      rst0_n = 0;
      @(negedge clk);
      rst0_n = 1;
      #1;
      cnt = 0;
      for (int n = 0; n < 100; n++) begin
         if (ready0) break;
         cnt++;
         @(negedge clk);
      end
      checks++; if (cnt !== 16) begin errors++; $display("FAIL clr_len: got %0d want 16", cnt); end
      access(1, 1, 0, 32'h0, 32'h0, 2'b10, 0, b, v, e, r);
      checks++; if (r !== 32'h0) begin errors++; $display("FAIL clr_w0: got %h want 0", r); end
      access(1, 1, 0, 32'h3C, 32'h0, 2'b10, 0, b, v, e, r);
      checks++; if (r !== 32'h0) begin errors++; $display("FAIL clr_w15: got %h want 0", r); end
   endtask
`endif

   initial begin
      rst_n = 0; rst0_n = 0;
      Address = 0; WriteData = 0; Size = 0; Unsigned = 0;
      mr1 = 0; mw1 = 0; mr0 = 0; mw0 = 0; sel_q = 0;
      test_reset();
      test_word();
      test_byte_half();
      test_errors();
      test_range();
      test_reset_mid();
      test_back_to_back();
`ifdef DMEM_CLEAR_EN
      test_clear();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/dmem_sized_ws.md
Name: dmem_sized_ws

Overview:
- Parametrised, clocked MIPS data memory; next generation of the single-word data memory, sitting between the MEM stage / multicycle datapath and its control unit.
- Adds configurable depth, byte/half/word access with sign/zero extension, a programmable wait-state latency with a Ready/ReadValid handshake, and address-error detection.
- Replaces the previous strobe-edge-triggered accesses with a single-clock FSM.

Parameters:
- DEPTH, 1024, number of 32-bit words; power of 2, 16..65536.
- WAIT_CYCLES, 1, extra access cycles inserted before the response; 0..15.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- Address  input  32  byte address; word index = Address[31:2].
- WriteData  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- MemWrite  input  1  store request, level.
- MemRead  input  1  load request, level.
- Size  input  2  00 byte, 01 half, 10 word, 11 illegal.
- Unsigned  input  1  loads only: 1 = zero-extend, 0 = sign-extend.
- Ready  output  1  block idle, can accept a request this cycle.
- ReadData  output  32  load result, extended.
- ReadValid  output  1  one-cycle pulse, ReadData valid.
- AddrErr  output  1  one-cycle pulse, request rejected.

Behaviour:
- Reset values: state IDLE, Ready 1, ReadData 0, ReadValid 0, AddrErr 0, wait counter 0. Memory array is not reset.
- States: IDLE, WAIT, RESP.
  - Ready = (state == IDLE), combinational from state.
- Accept: in IDLE at a rising edge with MemRead|MemWrite = 1.
  - Address, WriteData, Size, Unsigned and the direction are latched at that edge.
  - Inputs are don't-care afterwards until Ready returns.
- Error check at accept; any of the following sets the request as errored:
  - MemRead and MemWrite both 1.
  - Size == 11.
  - Half access with Address[0] = 1.
  - Word access with Address[1:0] != 00.
  - Address[31:2] >= DEPTH.
- Errored request:
  - IDLE -> RESP next edge, skipping WAIT.
  - AddrErr = 1 for the RESP cycle; ReadValid stays 0.
  - Memory is untouched and ReadData holds its previous value.
- Valid request:
  - IDLE -> WAIT if WAIT_CYCLES > 0, otherwise IDLE -> RESP.
  - WAIT lasts exactly WAIT_CYCLES cycles (counter loaded at accept, decremented each cycle), then -> RESP.
- Commit happens on the edge that enters RESP.
  - Stores: only the addressed lanes are updated; the others keep their value.
  - Loads: ReadData is registered on the same edge.
  - Lane order is little-endian: byte offset 0 = bits [7:0]; half offset 0 = bits [15:0].
- Load extension:
  - Byte: bit 7 of the lane replicated into [31:8] if Unsigned = 0, else zeros.
  - Half: bit 15 of the lane replicated into [31:16] if Unsigned = 0, else zeros.
  - Word: Unsigned is ignored.
- RESP:
  - Exactly one cycle; ReadValid = 1 for valid loads; then -> IDLE.
  - ReadData holds until the next load response.
- Latency:
  - Valid request: ReadValid is high during cycle WAIT_CYCLES+1 after the accept edge.
  - Throughput: one access per WAIT_CYCLES+2 cycles.
  - Errored request: response in cycle 1.
- Requests outside IDLE are ignored (no queueing); the master must hold its request until Ready.
- Reset mid-operation:
  - Immediate return to reset values.
  - A pending store that has not reached RESP is dropped; earlier stores are retained.

Optional Feature:
- Macro: DMEM_CLEAR_EN.
- Defined:
  - Adds a CLEAR state, entered on reset release.
  - Writes zero to one word per cycle, index 0..DEPTH-1, then -> IDLE.
  - Ready is held 0 and requests are ignored during CLEAR; clear takes exactly DEPTH cycles after the first edge with rst_n = 1.
  - Reset during CLEAR restarts the clear from index 0.
- Not defined: no CLEAR state; memory contents are undefined after power-up; Ready = 1 on the first cycle after reset.

Test Plan:
- WAIT_CYCLES=1: write Size=10 Address=0x10 data 0xDEADBEEF, then read word 0x10 -> Ready low 2 cycles; ReadValid pulses 2 cycles after accept; ReadData = 0xDEADBEEF.
- After the above:
  - Byte store 0x7F to 0x13 -> word at 0x10 = 0x7FADBEEF.
  - lb 0x12 -> 0xFFFFFFAD.
  - lbu 0x12 -> 0x000000AD.
  - lh 0x12 -> 0x00007FAD.
- Misaligned and illegal requests: lh at 0x11, lw at 0x12, Size=11 -> each gives AddrErr pulse one cycle after accept, ReadValid 0, memory unchanged (re-read 0x10 = 0x7FADBEEF).
- Out-of-range and both strobes:
  - DEPTH=1024, write to 0x1000 -> AddrErr pulse, no array change.
  - MemRead = MemWrite = 1 -> AddrErr pulse.
- Reset and back-to-back:
  - rst_n low during WAIT of a store to 0x20 (old value 0x11111111) -> outputs return to reset values; later read of 0x20 = 0x11111111.
  - Back-to-back reads with WAIT_CYCLES=0 -> ReadValid every 2nd cycle.
- DMEM_CLEAR_EN, DEPTH=16: release reset -> Ready 0 for exactly 16 cycles; read any word -> 0x00000000.
